sipo_deserializer: RTL and testbench

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

---
 rtl/sipo_pkg.sv | 35 +++
 rtl/sipo_shift_core.sv | 71 +++++++
 rtl/sipo_deserializer.sv | 93 +++++++++
 tb/tb_sipo_deserializer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_pkg
//  Description : Shared definitions for the SIPO deserializer slice: the
//                default seed word, lane-count legality check and the width
//                function for the per-word shift counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Default seed loaded into the assembly and holding registers.
  localparam logic [255:0] SIPO_INIT_256 = 256'h0;

  // Only power-of-two lane counts up to a byte are supported.
  function automatic bit sipo_lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8);
  endfunction

  // Full parameter legality: lanes legal, word an integral number of
  // beats, and at least two beats per word.
  function automatic bit sipo_params_legal(input int size, input int lanes,
                                           input int msb_first);
    return sipo_lanes_legal(lanes) && (size % lanes == 0) &&
           (size >= 2 * lanes) && (msb_first == 0 || msb_first == 1);
  endfunction

  // Counter width: enough bits for SIZE/LANES beats, never less than one.
  function automatic int sipo_cnt_w(input int size, input int lanes);
    int w;
    w = $clog2(size / lanes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_shift_core
//  Description : Assembly shift register and beat counter. Produces the
//                post-shift word combinationally together with a completion
//                strobe so the parent can capture a finished word on the very
//                edge that shifts its last beat in.
//  Ports       : clk, reset (async, active-high), clear (sync flush),
//                shift, s_in[LANES]     - inputs
//                live[SIZE], count[CNT_W], complete, word[SIZE] - outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int              SIZE      = 256,
  parameter int              LANES     = 1,
  parameter int              MSB_FIRST = 1,
  parameter logic [SIZE-1:0] INIT      = SIZE'(SIPO_INIT_256),
  localparam int             CNT_W     = sipo_cnt_w(SIZE, LANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [LANES-1:0] s_in,
  output logic [SIZE-1:0]  live,
  output logic [CNT_W-1:0] count,
  output logic             complete,
  output logic [SIZE-1:0]  word
);

  localparam int             c_beats = SIZE / LANES;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(c_beats - 1);

  logic [SIZE-1:0]  r_live;
  logic [CNT_W-1:0] r_count;
  logic [SIZE-1:0]  w_shifted;
  logic             w_last;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {r_live[SIZE-LANES-1:0], s_in};
    end else begin : g_lsb_first
      assign w_shifted = {s_in, r_live[SIZE-1:LANES]};
    end
  endgenerate

  assign w_last   = (r_count == c_last);
  // clear wins over a completing shift, so no word is offered then.
  assign complete = shift && !clear && w_last;
  assign word     = w_shifted;
  assign live     = r_live;
  assign count    = r_count;

  // live is not re-seeded on wrap; the next word simply shifts over it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_live  <= INIT;
      r_count <= '0;
    end else if (clear) begin
      r_live  <= INIT;
      r_count <= '0;
    end else if (shift) begin
      r_live  <= w_shifted;
      r_count <= w_last ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule : sipo_shift_core
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : sipo_deserializer
//  Description : Serial-in parallel-out deserializer with a one-word holding
//                register and valid/ready handshake. Completed words are
//                captured with zero added latency; a word completing while
//                the holding register is still occupied is dropped and the
//                sticky overrun flag raised.
//  Ports       : clk, reset (async, active-high), clear, shift, s_in[LANES],
//                out_ready                                      - inputs
//                live[SIZE], p_out[SIZE], out_valid, count[CNT_W],
//                overrun                                        - outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int              SIZE      = 256,
  parameter int              LANES     = 1,
  parameter int              MSB_FIRST = 1,
  parameter logic [SIZE-1:0] INIT      = SIZE'(SIPO_INIT_256),
  localparam int             CNT_W     = sipo_cnt_w(SIZE, LANES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [LANES-1:0] s_in,
  output logic [SIZE-1:0]  live,
  output logic [SIZE-1:0]  p_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             overrun
);

  generate
    if (!sipo_params_legal(SIZE, LANES, MSB_FIRST)) begin : g_bad_params
      $error("sipo_deserializer: illegal SIZE/LANES/MSB_FIRST combination");
    end
  endgenerate

  logic            w_complete;
  logic [SIZE-1:0] w_word;
  logic [SIZE-1:0] r_p_out;
  logic            r_out_valid;
  logic            r_overrun;

  sipo_shift_core #(
    .SIZE      (SIZE),
    .LANES     (LANES),
    .MSB_FIRST (MSB_FIRST),
    .INIT      (INIT)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .shift    (shift),
    .s_in     (s_in),
    .live     (live),
    .count    (count),
    .complete (w_complete),
    .word     (w_word)
  );

  // The holding register can take a new word if it is empty or is being
  // drained on this same edge; otherwise the new word is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p_out     <= INIT;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_complete) begin
      if (!r_out_valid || out_ready) begin
        r_p_out     <= w_word;
        r_out_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign p_out     = r_p_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule : sipo_deserializer
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sipo_deserializer
//  Description : Self-checking bench for three sipo_deserializer instances:
//                A = 8 bits, 1 lane, MSB first, seed 0
//                B = 8 bits, 2 lanes, LSB first, seed 8'h5A
//                C = default parameters (256 bits, 1 lane, MSB first)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

  localparam int             P_SIZE  [3] = '{8, 8, 256};
  localparam int             P_LANES [3] = '{1, 2, 1};
  localparam int             P_MSB   [3] = '{1, 0, 1};
  localparam logic [255:0]   P_INIT  [3] = '{256'h0, 256'h5A, 256'h0};

  logic       clk;
  logic       reset;
  logic       shift_v [3];
  logic       clear_v [3];
  logic       ready_v [3];
  logic [7:0] sin_v   [3];

  logic [7:0]   live_a, pout_a;
  logic [2:0]   count_a;
  logic         valid_a, ovr_a;
  logic [7:0]   live_b, pout_b;
  logic [1:0]   count_b;
  logic         valid_b, ovr_b;
  logic [255:0] live_c, pout_c;
  logic [7:0]   count_c;
  logic         valid_c, ovr_c;

  sipo_deserializer #(.SIZE(8), .LANES(1), .MSB_FIRST(1), .INIT(8'h00)) u_a (
    .clk(clk), .reset(reset), .clear(clear_v[0]), .shift(shift_v[0]),
    .s_in(sin_v[0][0:0]), .live(live_a), .p_out(pout_a), .out_valid(valid_a),
    .out_ready(ready_v[0]), .count(count_a), .overrun(ovr_a));

  sipo_deserializer #(.SIZE(8), .LANES(2), .MSB_FIRST(0), .INIT(8'h5A)) u_b (
    .clk(clk), .reset(reset), .clear(clear_v[1]), .shift(shift_v[1]),
    .s_in(sin_v[1][1:0]), .live(live_b), .p_out(pout_b), .out_valid(valid_b),
    .out_ready(ready_v[1]), .count(count_b), .overrun(ovr_b));

  sipo_deserializer u_c (
    .clk(clk), .reset(reset), .clear(clear_v[2]), .shift(shift_v[2]),
    .s_in(sin_v[2][0:0]), .live(live_c), .p_out(pout_c), .out_valid(valid_c),
    .out_ready(ready_v[2]), .count(count_c), .overrun(ovr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The word is treated as a bit window: each beat pushes LANES new bits in
  // from one end and lets the same number fall off the other end.
  logic [255:0] m_live [3];
  logic [255:0] m_pout [3];
  bit           m_valid [3];
  bit           m_ovr [3];
  int           m_cnt [3];

  task automatic model_edge(input int i);
    logic [255:0] mask, sv;
    bit           done;
    mask = {256{1'b1}} >> (256 - P_SIZE[i]);
    sv   = 256'(sin_v[i]) & ((256'd1 << P_LANES[i]) - 256'd1);
    done = 0;
    if (clear_v[i]) begin
      m_live[i] = P_INIT[i]; m_cnt[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
    end else begin
      if (shift_v[i]) begin
        if (P_MSB[i] == 1) m_live[i] = ((m_live[i] << P_LANES[i]) | sv) & mask;
        else               m_live[i] = (m_live[i] >> P_LANES[i]) | (sv << (P_SIZE[i] - P_LANES[i]));
        m_cnt[i] = m_cnt[i] + 1;
        if (m_cnt[i] == P_SIZE[i] / P_LANES[i]) begin
          m_cnt[i] = 0;
          done = 1;
        end
      end
      if (done) begin
        if (!m_valid[i] || ready_v[i]) begin
          m_pout[i] = m_live[i]; m_valid[i] = 1;
        end else begin
          m_ovr[i] = 1;
        end
      end else if (m_valid[i] && ready_v[i]) begin
        m_valid[i] = 0;
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_live[i] = P_INIT[i]; m_pout[i] = P_INIT[i];
        m_cnt[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
      end else begin
        model_edge(i);
      end
    end
  end

  // Compare every output of every instance on the falling edge.
  always @(negedge clk) begin
    chk("A.live",  256'(live_a),  m_live[0]);
    chk("A.p_out", 256'(pout_a),  m_pout[0]);
    chk("A.valid", 256'(valid_a), 256'(m_valid[0]));
    chk("A.count", 256'(count_a), 256'(m_cnt[0]));
    chk("A.ovr",   256'(ovr_a),   256'(m_ovr[0]));
    chk("B.live",  256'(live_b),  m_live[1]);
    chk("B.p_out", 256'(pout_b),  m_pout[1]);
    chk("B.valid", 256'(valid_b), 256'(m_valid[1]));
    chk("B.count", 256'(count_b), 256'(m_cnt[1]));
    chk("B.ovr",   256'(ovr_b),   256'(m_ovr[1]));
    chk("C.live",  live_c,        m_live[2]);
    chk("C.p_out", pout_c,        m_pout[2]);
    chk("C.valid", 256'(valid_c), 256'(m_valid[2]));
    chk("C.count", 256'(count_c), 256'(m_cnt[2]));
    chk("C.ovr",   256'(ovr_c),   256'(m_ovr[2]));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift one 8-bit word into A, MSB first; ready optionally high on the last beat.
  task automatic word_a(input logic [7:0] w, input logic rdy_last);
    for (int b = 7; b >= 0; b--) begin
      shift_v[0] = 1'b1;
      sin_v[0]   = {7'b0, w[b]};
      ready_v[0] = (b == 0) ? rdy_last : 1'b0;
      step();
    end
    shift_v[0] = 1'b0;
    ready_v[0] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      shift_v[i] = 0; clear_v[i] = 0; ready_v[i] = 0; sin_v[i] = '0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    step(); step();
    chk("rst_live_a",  256'(live_a),  256'h00);
    chk("rst_live_b",  256'(live_b),  256'h5A);
    chk("rst_pout_b",  256'(pout_b),  256'h5A);
    chk("rst_count_c", 256'(count_c), 256'h0);
    reset = 1'b0;
    step();

    // A: bits 1,0,1,1,0,0,1,0
    word_a(8'hB2, 1'b0);
    chk("A_word_pout",  256'(pout_a),  256'hB2);
    chk("A_word_valid", 256'(valid_a), 256'h1);
    chk("A_word_count", 256'(count_a), 256'h0);
    ready_v[0] = 1'b1; step(); ready_v[0] = 1'b0;
    chk("A_drain_valid", 256'(valid_a), 256'h0);

    // A: overrun
    word_a(8'hAA, 1'b0);
    word_a(8'h55, 1'b0);
    chk("A_ovr_pout", 256'(pout_a), 256'hAA);
    chk("A_ovr_flag", 256'(ovr_a),  256'h1);
    chk("A_ovr_live", 256'(live_a), 256'h55);
    ready_v[0] = 1'b1; step(); ready_v[0] = 1'b0;
    chk("A_ovr_drain_valid", 256'(valid_a), 256'h0);
    chk("A_ovr_sticky",      256'(ovr_a),   256'h1);
    clear_v[0] = 1'b1; shift_v[0] = 1'b1; sin_v[0] = 8'h1; step();
    clear_v[0] = 1'b0; shift_v[0] = 1'b0;
    chk("A_clr_ovr",   256'(ovr_a),   256'h0);
    chk("A_clr_count", 256'(count_a), 256'h0);
    chk("A_clr_pout",  256'(pout_a),  256'hAA);

    // A: completion coinciding with a transfer
    word_a(8'h3C, 1'b0);
    word_a(8'h81, 1'b1);
    chk("A_coin_pout",  256'(pout_a),  256'h81);
    chk("A_coin_valid", 256'(valid_a), 256'h1);
    chk("A_coin_ovr",   256'(ovr_a),   256'h0);

    // A: reset mid-word discards partial bits
    for (int k = 0; k < 3; k++) begin
      shift_v[0] = 1'b1; sin_v[0] = 8'h1; step();
    end
    shift_v[0] = 1'b0;
    do_reset();
    chk("A_rst_count", 256'(count_a), 256'h0);
    word_a(8'h96, 1'b0);
    chk("A_rst_word", 256'(pout_a), 256'h96);

    // B: lane pairs 01,10,11,00, LSB first
    begin
      logic [1:0] pairs [4];
      pairs = '{2'b01, 2'b10, 2'b11, 2'b00};
      for (int k = 0; k < 4; k++) begin
        shift_v[1] = 1'b1; sin_v[1] = {6'b0, pairs[k]}; step();
      end
      shift_v[1] = 1'b0;
    end
    chk("B_word_pout",  256'(pout_b),  256'h39);
    chk("B_word_valid", 256'(valid_b), 256'h1);
    shift_v[1] = 1'b1; sin_v[1] = 8'h3; step();
    clear_v[1] = 1'b1; step();
    clear_v[1] = 1'b0; shift_v[1] = 1'b0;
    chk("B_clr_live",  256'(live_b),  256'h5A);
    chk("B_clr_count", 256'(count_b), 256'h0);

    // C: 100 shifts, then reset
    for (int k = 0; k < 100; k++) begin
      shift_v[2] = 1'b1; sin_v[2] = 8'($urandom_range(0, 1)); step();
    end
    shift_v[2] = 1'b0;
    do_reset();
    chk("C_rst_live",  live_c,         256'h0);
    chk("C_rst_pout",  pout_c,         256'h0);
    chk("C_rst_count", 256'(count_c),  256'h0);
    for (int k = 0; k < 5; k++) begin
      shift_v[2] = 1'b1; sin_v[2] = 8'h1; step();
    end
    clear_v[2] = 1'b1; step();
    clear_v[2] = 1'b0; shift_v[2] = 1'b0;
    chk("C_clr_count", 256'(count_c), 256'h0);
    chk("C_clr_live",  live_c,        256'h0);

    // C: long random run across several word boundaries
    for (int k = 0; k < 800; k++) begin
      shift_v[2] = ($urandom_range(0, 3) != 0);
      sin_v[2]   = 8'($urandom_range(0, 1));
      ready_v[2] = ($urandom_range(0, 7) == 0);
      step();
    end
    shift_v[2] = 1'b0; ready_v[2] = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sipo_deserializer
`default_nettype wire
